// File: rtl/krnl_partialknn_uram_stream_reader.sv
// Streams len consecutive words out of a single-port URAM buffer as a ready/valid stream.
// Reads are credit-limited so that every word in flight is guaranteed a slot in the output FIFO.
module krnl_partialknn_uram_stream_reader #(
    parameter int DATA_WIDTH   = 256,
    parameter int ADDR_RANGE   = 2048,
    parameter int ADDR_WIDTH   = 11,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] address0,
    output logic                  ce0,
    output logic                  we0,
    output logic [DATA_WIDTH-1:0] d0,
    input  logic [DATA_WIDTH-1:0] q0,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = $clog2(FIFO_DEPTH + READ_LATENCY + 2) + 1;
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_TOP = ADDR_WIDTH'(ADDR_RANGE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    ce0_q, ce0_d;
    logic [ADDR_WIDTH-1:0]   address0_q, address0_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH:0]     len_q, len_d;
    logic [ADDR_WIDTH:0]     iss_left_q, iss_left_d;
    logic [ADDR_WIDTH:0]     push_cnt_q, push_cnt_d;
    logic [READ_LATENCY-1:0] rd_vld_q, rd_vld_d;
    logic [CNT_W-1:0]        fifo_cnt_q, fifo_cnt_d;
    logic [FIFO_DEPTH-1:0]   fifo_last_q, fifo_last_d;
    logic [DATA_WIDTH-1:0]   fifo_data_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   fifo_data_d [FIFO_DEPTH];
    logic                    m_valid_q, m_valid_d;

    logic                    push;
    logic                    pop;
    logic                    push_last;
    logic                    credit_ok;
    logic [OCC_W-1:0]        occ;
    logic [CNT_W-1:0]        wr_idx;

    // A read tag leaves the shift register exactly when its q0 word is valid.
    assign push      = rd_vld_q[READ_LATENCY-1];
    assign pop       = m_valid_q & m_ready;
    assign push_last = (push_cnt_q == (len_q - LEN_ONE));

    // Slots already spoken for next cycle: the read on the bus now, tags in flight, and FIFO contents.
    always_comb begin
        occ = OCC_W'(ce0_q) + OCC_W'(fifo_cnt_q);
        for (int i = 0; i < READ_LATENCY; i++) begin
            occ = occ + OCC_W'(rd_vld_q[i]);
        end
        occ = occ - OCC_W'(pop);
        credit_ok = (occ < OCC_W'(FIFO_DEPTH));
    end

    always_comb begin
        rd_vld_d    = '0;
        rd_vld_d[0] = ce0_q;
        for (int i = 1; i < READ_LATENCY; i++) begin
            rd_vld_d[i] = rd_vld_q[i-1];
        end
    end

    // Shift-register FIFO: entry 0 is always the head, so the stream outputs come straight from flops.
    always_comb begin
        fifo_cnt_d  = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
        fifo_last_d = fifo_last_q;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data_d[i] = fifo_data_q[i];
        end
        if (pop) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                fifo_data_d[i] = fifo_data_q[i+1];
                fifo_last_d[i] = fifo_last_q[i+1];
            end
            fifo_last_d[FIFO_DEPTH-1] = 1'b0;
        end
        wr_idx = fifo_cnt_q - CNT_W'(pop);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (push && (wr_idx == CNT_W'(i))) begin
                fifo_data_d[i] = q0;
                fifo_last_d[i] = push_last;
            end
        end
        m_valid_d = (fifo_cnt_d != '0);
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        iss_left_d = iss_left_q;
        addr_d     = addr_q;
        address0_d = address0_q;
        ce0_d      = 1'b0;
        push_cnt_d = push ? (push_cnt_q + LEN_ONE) : push_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d    = ST_ISSUE;
                        len_d      = len;
                        iss_left_d = len;
                        addr_d     = base_addr;
                        push_cnt_d = '0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ISSUE: begin
                if (credit_ok) begin
                    ce0_d      = 1'b1;
                    address0_d = addr_q;
                    addr_d     = (addr_q == ADDR_TOP) ? '0 : (addr_q + ADDR_ONE);
                    iss_left_d = iss_left_q - LEN_ONE;
                    if (iss_left_q == LEN_ONE) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && fifo_last_q[0]) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ce0_q       <= 1'b0;
            address0_q  <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            iss_left_q  <= '0;
            push_cnt_q  <= '0;
            rd_vld_q    <= '0;
            fifo_cnt_q  <= '0;
            fifo_last_q <= '0;
            m_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ce0_q       <= ce0_d;
            address0_q  <= address0_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            iss_left_q  <= iss_left_d;
            push_cnt_q  <= push_cnt_d;
            rd_vld_q    <= rd_vld_d;
            fifo_cnt_q  <= fifo_cnt_d;
            fifo_last_q <= fifo_last_d;
            m_valid_q   <= m_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data_q[i] <= fifo_data_d[i];
        end
    end

    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && !pop && (fifo_cnt_q == CNT_W'(FIFO_DEPTH))));

    assign busy     = busy_q;
    assign done     = done_q;
    assign ce0      = ce0_q;
    assign address0 = address0_q;
    assign we0      = 1'b0;
    assign d0       = '0;
    assign m_data   = fifo_data_q[0];
    assign m_valid  = m_valid_q;
    assign m_last   = fifo_last_q[0];

endmodule
